// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Redirect priority: EX branch, then load-use stall, then ID J/JAL, then ID JR/JALR, then sequential fetch.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [1:0]  pc_src,
   input  logic [31:0] rs_data,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_rdata,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        id_ex_flush,
   output logic [31:0] fetch_count
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] count_q, count_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      count_d = count_q;
      if (branch_taken) begin
         pc_d    = {branch_target[31:2], 2'b00};
         inst_d  = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (stall) begin
         // Hold everything; a pending ID jump is taken once the stall clears.
      end else if (valid_q && (pc_src == 2'b01)) begin
         pc_d    = {pc4_q[31:28], inst_q[25:0], 2'b00};
         inst_d  = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (valid_q && (pc_src == 2'b10)) begin
         pc_d    = {rs_data[31:2], 2'b00};
         inst_d  = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else begin
         pc_d    = pc_plus4;
         inst_d  = inst_rdata;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign inst_addr   = pc_q;
   assign if_id_inst  = inst_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign fetch_count = count_q;
   assign id_ex_flush = branch_taken | stall;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, sequential fetch, J, stalled JR, branch priority, async reset, PC wrap.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [1:0]  pc_src;
   logic [31:0] rs_data;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        id_ex_flush;
   logic [31:0] fetch_count;

   int unsigned checks;
   int unsigned fails;

   fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
      .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src), .rs_data(rs_data),
      .branch_taken(branch_taken), .branch_target(branch_target), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
      .if_id_valid(if_id_valid), .id_ex_flush(id_ex_flush), .fetch_count(fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; pc_src = 2'b00; rs_data = '0;
      branch_taken = 1'b0; branch_target = '0; inst_rdata = 32'h2008_0001;
      #12;
      if (inst_addr !== 32'h0040_0000) begin $display("FAIL reset_pc: got %h exp %h", inst_addr, 32'h0040_0000); fails++; end checks++;
      if (if_id_inst !== 32'h0) begin $display("FAIL reset_inst: got %h exp 0", if_id_inst); fails++; end checks++;
      if (if_id_pc4 !== 32'h0) begin $display("FAIL reset_pc4: got %h exp 0", if_id_pc4); fails++; end checks++;
      if (if_id_valid !== 1'b0) begin $display("FAIL reset_valid: got %b exp 0", if_id_valid); fails++; end checks++;
      if (fetch_count !== 32'h0) begin $display("FAIL reset_count: got %0d exp 0", fetch_count); fails++; end checks++;
      if (id_ex_flush !== 1'b0) begin $display("FAIL reset_flush: got %b exp 0", id_ex_flush); fails++; end checks++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      exp_pc = 32'h0040_0000;
      for (int i = 1; i <= 3; i++) begin
         tick();
         exp_pc = exp_pc + 32'd4;
         if (inst_addr !== exp_pc) begin $display("FAIL seq_pc[%0d]: got %h exp %h", i, inst_addr, exp_pc); fails++; end checks++;
         if (if_id_pc4 !== exp_pc) begin $display("FAIL seq_pc4[%0d]: got %h exp %h", i, if_id_pc4, exp_pc); fails++; end checks++;
         if (if_id_inst !== 32'h2008_0001) begin $display("FAIL seq_inst[%0d]: got %h exp %h", i, if_id_inst, 32'h2008_0001); fails++; end checks++;
         if (if_id_valid !== 1'b1) begin $display("FAIL seq_valid[%0d]: got %b exp 1", i, if_id_valid); fails++; end checks++;
      end
      if (fetch_count !== 32'd3) begin $display("FAIL seq_count: got %0d exp 3", fetch_count); fails++; end checks++;
   endtask

   task automatic test_jump();
      inst_rdata = 32'h0810_0010;
      tick();
      if (if_id_inst !== 32'h0810_0010) begin $display("FAIL j_inst: got %h exp %h", if_id_inst, 32'h0810_0010); fails++; end checks++;
      if (fetch_count !== 32'd4) begin $display("FAIL j_count_pre: got %0d exp 4", fetch_count); fails++; end checks++;
      pc_src = 2'b01;
      inst_rdata = 32'h0000_0020;
      #1;
      if (id_ex_flush !== 1'b0) begin $display("FAIL j_flush: got %b exp 0", id_ex_flush); fails++; end checks++;
      tick();
      if (inst_addr !== 32'h0040_0040) begin $display("FAIL j_pc: got %h exp %h", inst_addr, 32'h0040_0040); fails++; end checks++;
      if (if_id_valid !== 1'b0) begin $display("FAIL j_valid: got %b exp 0", if_id_valid); fails++; end checks++;
      if (if_id_inst !== 32'h0) begin $display("FAIL j_bubble: got %h exp 0", if_id_inst); fails++; end checks++;
      if (fetch_count !== 32'd4) begin $display("FAIL j_count: got %0d exp 4", fetch_count); fails++; end checks++;
      // pc_src still 01 but IF/ID is a bubble: must fetch sequentially
      tick();
      if (inst_addr !== 32'h0040_0044) begin $display("FAIL j_ignore_pc: got %h exp %h", inst_addr, 32'h0040_0044); fails++; end checks++;
      if (if_id_valid !== 1'b1) begin $display("FAIL j_ignore_valid: got %b exp 1", if_id_valid); fails++; end checks++;
      if (if_id_pc4 !== 32'h0040_0044) begin $display("FAIL j_ignore_pc4: got %h exp %h", if_id_pc4, 32'h0040_0044); fails++; end checks++;
      if (fetch_count !== 32'd5) begin $display("FAIL j_ignore_count: got %0d exp 5", fetch_count); fails++; end checks++;
      pc_src = 2'b00;
   endtask

   task automatic test_jr_stall();
      stall = 1'b1; pc_src = 2'b10; rs_data = 32'h0040_0123; inst_rdata = 32'h1111_1111;
      #1;
      if (id_ex_flush !== 1'b1) begin $display("FAIL jr_flush: got %b exp 1", id_ex_flush); fails++; end checks++;
      tick();
      if (inst_addr !== 32'h0040_0044) begin $display("FAIL jr_hold_pc: got %h exp %h", inst_addr, 32'h0040_0044); fails++; end checks++;
      if (if_id_inst !== 32'h0000_0020) begin $display("FAIL jr_hold_inst: got %h exp %h", if_id_inst, 32'h0000_0020); fails++; end checks++;
      if (if_id_valid !== 1'b1) begin $display("FAIL jr_hold_valid: got %b exp 1", if_id_valid); fails++; end checks++;
      if (fetch_count !== 32'd5) begin $display("FAIL jr_hold_count: got %0d exp 5", fetch_count); fails++; end checks++;
      stall = 1'b0;
      #1;
      if (id_ex_flush !== 1'b0) begin $display("FAIL jr_flush_clr: got %b exp 0", id_ex_flush); fails++; end checks++;
      tick();
      if (inst_addr !== 32'h0040_0120) begin $display("FAIL jr_pc: got %h exp %h", inst_addr, 32'h0040_0120); fails++; end checks++;
      if (if_id_valid !== 1'b0) begin $display("FAIL jr_valid: got %b exp 0", if_id_valid); fails++; end checks++;
      if (fetch_count !== 32'd5) begin $display("FAIL jr_count: got %0d exp 5", fetch_count); fails++; end checks++;
      pc_src = 2'b00;
   endtask

   task automatic test_branch_priority();
      inst_rdata = 32'h2008_0001;
      tick();
      if (inst_addr !== 32'h0040_0124) begin $display("FAIL br_pre_pc: got %h exp %h", inst_addr, 32'h0040_0124); fails++; end checks++;
      if (fetch_count !== 32'd6) begin $display("FAIL br_pre_count: got %0d exp 6", fetch_count); fails++; end checks++;
      branch_taken = 1'b1; branch_target = 32'h0040_0203; stall = 1'b1; pc_src = 2'b01;
      #1;
      if (id_ex_flush !== 1'b1) begin $display("FAIL br_flush: got %b exp 1", id_ex_flush); fails++; end checks++;
      tick();
      if (inst_addr !== 32'h0040_0200) begin $display("FAIL br_pc: got %h exp %h", inst_addr, 32'h0040_0200); fails++; end checks++;
      if (if_id_inst !== 32'h0) begin $display("FAIL br_inst: got %h exp 0", if_id_inst); fails++; end checks++;
      if (if_id_pc4 !== 32'h0) begin $display("FAIL br_pc4: got %h exp 0", if_id_pc4); fails++; end checks++;
      if (if_id_valid !== 1'b0) begin $display("FAIL br_valid: got %b exp 0", if_id_valid); fails++; end checks++;
      if (fetch_count !== 32'd6) begin $display("FAIL br_count: got %0d exp 6", fetch_count); fails++; end checks++;
      branch_taken = 1'b0; stall = 1'b0; pc_src = 2'b00; branch_target = '0;
   endtask

   task automatic test_async_reset();
      tick();
      if (inst_addr !== 32'h0040_0204) begin $display("FAIL ar_pre_pc: got %h exp %h", inst_addr, 32'h0040_0204); fails++; end checks++;
      #2;
      reset = 1'b1;
      #1;
      if (inst_addr !== 32'h0040_0000) begin $display("FAIL ar_pc: got %h exp %h", inst_addr, 32'h0040_0000); fails++; end checks++;
      if (if_id_valid !== 1'b0) begin $display("FAIL ar_valid: got %b exp 0", if_id_valid); fails++; end checks++;
      if (if_id_inst !== 32'h0) begin $display("FAIL ar_inst: got %h exp 0", if_id_inst); fails++; end checks++;
      if (if_id_pc4 !== 32'h0) begin $display("FAIL ar_pc4: got %h exp 0", if_id_pc4); fails++; end checks++;
      if (fetch_count !== 32'h0) begin $display("FAIL ar_count: got %0d exp 0", fetch_count); fails++; end checks++;
      #1;
      reset = 1'b0;
      tick();
      if (inst_addr !== 32'h0040_0004) begin $display("FAIL ar_first_pc: got %h exp %h", inst_addr, 32'h0040_0004); fails++; end checks++;
      if (if_id_pc4 !== 32'h0040_0004) begin $display("FAIL ar_first_pc4: got %h exp %h", if_id_pc4, 32'h0040_0004); fails++; end checks++;
      if (if_id_valid !== 1'b1) begin $display("FAIL ar_first_valid: got %b exp 1", if_id_valid); fails++; end checks++;
      if (fetch_count !== 32'd1) begin $display("FAIL ar_first_count: got %0d exp 1", fetch_count); fails++; end checks++;
   endtask

   task automatic test_wrap();
      pc_src = 2'b10; rs_data = 32'hFFFF_FFFE;
      tick();
      if (inst_addr !== 32'hFFFF_FFFC) begin $display("FAIL wrap_jr_pc: got %h exp %h", inst_addr, 32'hFFFF_FFFC); fails++; end checks++;
      pc_src = 2'b00; inst_rdata = 32'hABCD_0123;
      tick();
      if (inst_addr !== 32'h0) begin $display("FAIL wrap_pc: got %h exp 0", inst_addr); fails++; end checks++;
      if (if_id_pc4 !== 32'h0) begin $display("FAIL wrap_pc4: got %h exp 0", if_id_pc4); fails++; end checks++;
      if (if_id_valid !== 1'b1) begin $display("FAIL wrap_valid: got %b exp 1", if_id_valid); fails++; end checks++;
      if (if_id_inst !== 32'hABCD_0123) begin $display("FAIL wrap_inst: got %h exp %h", if_id_inst, 32'hABCD_0123); fails++; end checks++;
      if (fetch_count !== 32'd2) begin $display("FAIL wrap_count: got %0d exp 2", fetch_count); fails++; end checks++;
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_sequential();
      test_jump();
      test_jr_stall();
      test_branch_priority();
      test_async_reset();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
